// File: rtl/mult_pkg.sv
// Shared types and constants for the mult32x32 dispatch front end.
package mult_pkg;

    localparam int MULT_W = 32;

    // One queued operand pair, as held in the operand FIFO.
    typedef struct packed {
        logic [MULT_W-1:0] a;
        logic [MULT_W-1:0] b;
    } mult_ops_t;

    // Dispatch sequencer states.
    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        RESULT
    } disp_state_t;

endpackage

// File: rtl/mult32x32_dispatch_if.sv
// Bundle of the operand stream, the multiplier handshake and the result stream.
//
// Handshake rule for both streams (in_*, out_*): a transfer happens on a
// posedge where valid and ready are both 1. The producer holds valid and its
// data stable until that transfer; ready may change freely and never depends
// combinationally on valid.
interface mult32x32_dispatch_if;
    import mult_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [MULT_W-1:0]     in_a;
    logic [MULT_W-1:0]     in_b;

    logic                  mult_start;
    logic [MULT_W-1:0]     mult_a;
    logic [MULT_W-1:0]     mult_b;
    logic                  mult_busy;
    logic [2*MULT_W-1:0]   mult_product;

    logic                  out_valid;
    logic                  out_ready;
    logic [2*MULT_W-1:0]   out_product;

    // Dispatch block side.
    modport slave (
        input  in_valid, in_a, in_b, mult_busy, mult_product, out_ready,
        output in_ready, mult_start, mult_a, mult_b, out_valid, out_product
    );

    // Environment side: operand source, multiplier and result sink.
    modport master (
        output in_valid, in_a, in_b, mult_busy, mult_product, out_ready,
        input  in_ready, mult_start, mult_a, mult_b, out_valid, out_product
    );

endinterface

// File: rtl/mult_op_fifo.sv
// Synchronous operand-pair FIFO. The caller only pushes when !full and only
// pops when !empty; push and pop in the same cycle are both honoured.
module mult_op_fifo
    import mult_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  mult_ops_t        din,
    input  logic             pop,
    output mult_ops_t        dout,
    output logic             full,
    output logic             empty,
    output logic [DEPTH:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    mult_ops_t        mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;

    // Storage write; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    // Occupancy tracking; simultaneous push and pop leave it unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rptr];
    assign full  = (count == (DEPTH+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/mult32x32_dispatch.sv
// Feeds operand pairs from a small FIFO to mult32x32_fast one at a time and
// returns each 64-bit product downstream, in issue order.
module mult32x32_dispatch
    import mult_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    mult32x32_dispatch_if.slave    bus,
    output disp_state_t            dbg_state,
    output logic [FIFO_DEPTH:0]    dbg_count
);

    localparam int TO_W = $clog2(BUSY_TIMEOUT + 1);

    disp_state_t      state;
    disp_state_t      state_next;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    mult_ops_t        fifo_din;
    mult_ops_t        fifo_head;
    logic [FIFO_DEPTH:0] fifo_count;
    logic             start;
    logic             load_result;
    logic [TO_W-1:0]  tcnt;

    // Input side: no pass-through, and nothing is accepted while in reset.
    assign bus.in_ready = !fifo_full && !reset;
    assign fifo_push    = bus.in_valid && bus.in_ready;
    assign fifo_din     = '{a: bus.in_a, b: bus.in_b};

    mult_op_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Sequencer next-state and control strobes.
    always_comb begin
        state_next  = state;
        fifo_pop    = 1'b0;
        start       = 1'b0;
        load_result = 1'b0;
        case (state)
            IDLE: begin
                // Holding off while busy covers a multiplier still finishing
                // an op that a reset abandoned; normally busy is already low.
                if (!fifo_empty && !bus.mult_busy) begin
                    fifo_pop   = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                start      = 1'b1;
                state_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.mult_busy) begin
                    state_next = WAIT_DONE;
                end else if (tcnt == TO_W'(BUSY_TIMEOUT - 1)) begin
                    state_next = RESULT;
                end
            end
            WAIT_DONE: begin
                if (!bus.mult_busy) begin
                    state_next = RESULT;
                end
            end
            RESULT: begin
                if (!bus.out_valid || bus.out_ready) begin
                    load_result = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand registers: loaded on pop, held until the next pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.mult_a <= '0;
            bus.mult_b <= '0;
        end else if (fifo_pop) begin
            bus.mult_a <= fifo_head.a;
            bus.mult_b <= fifo_head.b;
        end
    end

    // Bounds the wait for a busy pulse that may never come.
    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt <= '0;
        end else if (state == ISSUE) begin
            tcnt <= '0;
        end else if (state == WAIT_BUSY) begin
            tcnt <= tcnt + 1'b1;
        end
    end

    // Result register; a reload in RESULT takes priority over a drain.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_valid   <= 1'b0;
            bus.out_product <= '0;
        end else if (load_result) begin
            bus.out_valid   <= 1'b1;
            bus.out_product <= bus.mult_product;
        end else if (bus.out_ready) begin
            bus.out_valid   <= 1'b0;
        end
    end

    assign bus.mult_start = start;
    assign dbg_state      = state;
    assign dbg_count      = fifo_count;

endmodule

// File: tb/tb_mult32x32_dispatch.sv
// Directed bench for mult32x32_dispatch with a behavioural stand-in for
// mult32x32_fast whose busy duration is set per test.
module tb_mult32x32_dispatch;
    import mult_pkg::*;

    localparam int HALF_PERIOD  = 5;
    localparam int FIFO_DEPTH   = 4;
    localparam int BUSY_TIMEOUT = 4;

    logic                clk   = 1'b0;
    logic                reset = 1'b1;
    disp_state_t         dbg_state;
    logic [FIFO_DEPTH:0] dbg_count;

    mult32x32_dispatch_if bus ();

    mult32x32_dispatch #(
        .FIFO_DEPTH   (FIFO_DEPTH),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state),
        .dbg_count (dbg_count)
    );

    // ---------------- clock ----------------
    always #(HALF_PERIOD) clk = ~clk;

    // ---------------- multiplier stand-in ----------------
    int           mult_lat = 3;
    int           mcnt     = 0;
    logic         mbusy    = 1'b0;
    logic [63:0]  mprod    = 64'd0;

    assign bus.mult_busy    = mbusy;
    assign bus.mult_product = mprod;

    always @(posedge clk) begin
        if (bus.mult_start) begin
            if (mult_lat == 0) begin
                mprod <= {32'd0, bus.mult_a} * {32'd0, bus.mult_b};
            end else begin
                mbusy <= 1'b1;
                mcnt  <= mult_lat;
            end
        end else if (mbusy) begin
            if (mcnt == 1) begin
                mbusy <= 1'b0;
                mprod <= {32'd0, bus.mult_a} * {32'd0, bus.mult_b};
            end
            mcnt <= mcnt - 1;
        end
    end

    // ---------------- scoreboard ----------------
    int          checks   = 0;
    int          failures = 0;
    int          starts   = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Sampled on the falling edge: counts starts and checks every transfer.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.mult_start) begin
                starts++;
                check("start_while_busy", {63'd0, bus.mult_busy}, 64'd0);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", {63'd0, bus.out_valid}, 64'd0);
                end else begin
                    check("out_product", bus.out_product, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
        int   n = 0;
        logic rdy;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        while (1) begin
            rdy = bus.in_ready;
            tick();
            if (rdy) begin
                exp_q.push_back(exp);
                break;
            end
            n++;
            if (n >= 200) begin
                check("push_timeout", 64'(n), 64'd0);
                break;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_state(input disp_state_t s, input logic need_valid, input string tag);
        int n = 0;
        while (!(dbg_state == s && (!need_valid || bus.out_valid)) && n < 100) begin
            tick();
            n++;
        end
        check(tag, 64'(dbg_state), 64'(s));
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        check("drain_left", 64'(exp_q.size()), 64'd0);
        tick();
    endtask

    // Stalls downstream, then parks the second product in RESULT behind the first.
    task automatic park_two(input logic [31:0] a0, input logic [31:0] b0, input logic [63:0] p0,
                            input logic [31:0] a1, input logic [31:0] b1, input logic [63:0] p1);
        bus.out_ready = 1'b0;
        push(a0, b0, p0);
        push(a1, b1, p1);
        wait_state(RESULT, 1'b1, "park_result");
    endtask

    // ---------------- main sequence ----------------
    logic [31:0] burst_a [5] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
    logic [31:0] burst_b [5] = '{32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
    logic [63:0] burst_p [5] = '{64'd2, 64'd6, 64'd12, 64'd20, 64'd30};

    initial begin
        int k;
        int s0;

        bus.in_valid  = 1'b0;
        bus.in_a      = 32'd0;
        bus.in_b      = 32'd0;
        bus.out_ready = 1'b1;

        // Reset state.
        reset = 1'b1;
        tick(); tick(); tick();
        check("rst_in_ready",   {63'd0, bus.in_ready},   64'd0);
        check("rst_out_valid",  {63'd0, bus.out_valid},  64'd0);
        check("rst_mult_start", {63'd0, bus.mult_start}, 64'd0);
        check("rst_out_product", bus.out_product,        64'd0);
        check("rst_mult_a",     {32'd0, bus.mult_a},     64'd0);
        check("rst_state",      64'(dbg_state),          64'(IDLE));
        reset = 1'b0;
        tick();
        check("in_ready_after_rst", {63'd0, bus.in_ready}, 64'd1);

        // 1. Single op: latency and exactly one start.
        s0 = starts;
        push(32'd309518561, 32'd316276955, 64'd97893587989061755);
        k = 0;
        while (!bus.out_valid && k < 50) begin
            tick();
            k++;
        end
        check("latency", 64'(k), 64'd7);
        drain();
        check("single_start", 64'(starts - s0), 64'd1);

        // 2. Low halves and maximum operands.
        push(32'd57569, 32'd219, 64'd12607611);
        push(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        drain();

        // 3. Burst into a stalled pipeline: FIFO fills after FIFO_DEPTH pushes.
        park_two(32'd11, 32'd13, 64'd143, 32'd17, 32'd19, 64'd323);
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            push(burst_a[i], burst_b[i], burst_p[i]);
        end
        check("burst_full_ready", {63'd0, bus.in_ready}, 64'd0);
        check("burst_full_count", 64'(dbg_count), 64'(FIFO_DEPTH));
        bus.out_ready = 1'b1;
        push(burst_a[4], burst_b[4], burst_p[4]);
        drain();

        // 4. Back-pressure: first product held, FSM parked in RESULT.
        park_two(32'd100, 32'd200, 64'd20000, 32'd7, 32'd8, 64'd56);
        for (int i = 0; i < 20; i++) begin
            check("bp_valid",   {63'd0, bus.out_valid}, 64'd1);
            check("bp_product", bus.out_product,        64'd20000);
            check("bp_state",   64'(dbg_state),         64'(RESULT));
            tick();
        end
        bus.out_ready = 1'b1;
        drain();

        // 6. Push and pop in the same cycle with FIFO at FIFO_DEPTH-1.
        park_two(32'd3, 32'd4, 64'd12, 32'd5, 32'd6, 64'd30);
        push(32'd9,  32'd10, 64'd90);
        push(32'd11, 32'd12, 64'd132);
        push(32'd13, 32'd14, 64'd182);
        check("pp_count_before", 64'(dbg_count), 64'(FIFO_DEPTH - 1));
        bus.out_ready = 1'b1;
        tick();
        check("pp_state_idle", 64'(dbg_state), 64'(IDLE));
        bus.in_valid = 1'b1;
        bus.in_a     = 32'd15;
        bus.in_b     = 32'd16;
        check("pp_in_ready", {63'd0, bus.in_ready}, 64'd1);
        tick();
        bus.in_valid = 1'b0;
        exp_q.push_back(64'd240);
        check("pp_count_after", 64'(dbg_count), 64'(FIFO_DEPTH - 1));
        check("pp_state_issue", 64'(dbg_state), 64'(ISSUE));
        drain();

        // Busy never asserted: timeout path still delivers the product.
        mult_lat = 0;
        s0 = starts;
        push(32'd6, 32'd7, 64'd42);
        drain();
        check("timeout_start", 64'(starts - s0), 64'd1);
        mult_lat = 3;

        // 5. Reset during WAIT_DONE with two entries queued.
        mult_lat = 8;
        push(32'd21, 32'd22, 64'd462);
        push(32'd23, 32'd24, 64'd552);
        push(32'd25, 32'd26, 64'd650);
        wait_state(WAIT_DONE, 1'b0, "mid_wait_done");
        check("mid_count", 64'(dbg_count), 64'd2);
        reset = 1'b1;
        exp_q.delete();
        tick();
        check("mid_out_valid",   {63'd0, bus.out_valid},  64'd0);
        check("mid_mult_start",  {63'd0, bus.mult_start}, 64'd0);
        check("mid_in_ready",    {63'd0, bus.in_ready},   64'd0);
        check("mid_state",       64'(dbg_state),          64'(IDLE));
        check("mid_count_flush", 64'(dbg_count),          64'd0);
        check("mid_out_product", bus.out_product,         64'd0);
        reset = 1'b0;
        tick();
        check("mid_in_ready_up", {63'd0, bus.in_ready}, 64'd1);
        k = 0;
        while (mbusy && k < 50) begin
            tick();
            k++;
        end
        for (int i = 0; i < 20; i++) begin
            tick();
        end
        check("mid_no_stale", {63'd0, bus.out_valid}, 64'd0);
        mult_lat = 3;
        push(32'd27, 32'd28, 64'd756);
        drain();

        tick(); tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop if the sequence ever wedges.
    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog got=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
